// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin owner of a shared 2:1 mux select with bounded tenure and registered output.
// Optional MUX_ARB_LOCK_EN adds a lock input that lets the owner extend its tenure past MAX_HOLD.
module mux2_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef MUX_ARB_LOCK_EN
  input  logic         lock,
`endif
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         s,
  output logic [W-1:0] z,
  output logic         z_valid
);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_q, last_d, s_q, s_d, zv_q, lock_w, expire;
  logic [W-1:0]  z_q, z_d;
`ifdef MUX_ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif
  // last_q=1 means B was granted most recently, so A wins the next tie
  assign expire = (hold_q == HOLD_MAX) && !lock_w;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (req_a && req_b) ? (last_q ? GNT_A : GNT_B) : req_a ? GNT_A : req_b ? GNT_B : IDLE;
      GNT_A:   state_d = !req_a ? (req_b ? GNT_B : IDLE) : (req_b && expire) ? GNT_B : GNT_A;
      GNT_B:   state_d = !req_b ? (req_a ? GNT_A : IDLE) : (req_a && expire) ? GNT_A : GNT_B;
      default: state_d = IDLE;
    endcase
    hold_d = (state_d != state_q) ? '0 : (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
    last_d = (state_d == GNT_A) ? 1'b0 : (state_d == GNT_B) ? 1'b1 : last_q;
    s_d    = (state_d == GNT_A) ? 1'b0 : (state_d == GNT_B) ? 1'b1 : s_q;
    z_d    = (state_q == GNT_B) ? b : (state_q == GNT_A) ? a : z_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
      z_q     <= '0;
      zv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      s_q     <= s_d;
      z_q     <= z_d;
      zv_q    <= (state_q != IDLE);
    end
  end
  assign gnt_a   = (state_q == GNT_A);
  assign gnt_b   = (state_q == GNT_B);
  assign s       = s_q;
  assign z       = z_q;
  assign z_valid = zv_q;
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: vector table through a scoreboard queue, then async reset, MAX_HOLD=1 and lock sequences.
module tb_mux2_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [7:0] a = 8'hA1, b = 8'hB2;
  logic gnt_a, gnt_b, s, z_valid, gnt_a1, gnt_b1, s1, z_valid1;
  logic [7:0] z, z1;
`ifdef MUX_ARB_LOCK_EN
  logic lock = 1'b0;
`endif
  int errors = 0, checks = 0;
  typedef struct packed {
    logic ra, rb, ga, gb, s;
    logic [7:0] z;
    logic zv;
  } vec_t;
  vec_t vecs[26];
  vec_t sb[$];
  always #5 clk = ~clk;
  mux2_arbiter #(.W(8), .MAX_HOLD(4)) u0 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
`ifdef MUX_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt_a(gnt_a), .gnt_b(gnt_b), .s(s), .z(z), .z_valid(z_valid));
  mux2_arbiter #(.W(8), .MAX_HOLD(1)) u1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
`ifdef MUX_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .s(s1), .z(z1), .z_valid(z_valid1));
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int idx);
    vec_t e;
    req_a = vecs[idx].ra;
    req_b = vecs[idx].rb;
    sb.push_back(vecs[idx]);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d", idx), {4'h0, gnt_a, gnt_b, s, z, z_valid}, {4'h0, e.ga, e.gb, e.s, e.z, e.zv});
    check($sformatf("excl%0d", idx), {15'h0, gnt_a & gnt_b}, 16'h0);
  endtask
  initial begin
    // {ra, rb, ga, gb, s, z, zv}: expected values are those seen just after the edge the inputs are sampled on
    vecs = '{
      '{1,0, 1,0,0, 8'h00,0}, '{1,0, 1,0,0, 8'hA1,1}, '{1,0, 1,0,0, 8'hA1,1},
      '{1,0, 1,0,0, 8'hA1,1}, '{1,0, 1,0,0, 8'hA1,1}, '{1,0, 1,0,0, 8'hA1,1},
      '{1,1, 0,1,1, 8'hA1,1}, '{1,1, 0,1,1, 8'hB2,1}, '{1,1, 0,1,1, 8'hB2,1},
      '{1,1, 0,1,1, 8'hB2,1}, '{1,1, 1,0,0, 8'hB2,1}, '{1,1, 1,0,0, 8'hA1,1},
      '{1,1, 1,0,0, 8'hA1,1}, '{1,1, 1,0,0, 8'hA1,1}, '{0,1, 0,1,1, 8'hA1,1},
      '{0,1, 0,1,1, 8'hB2,1}, '{0,0, 0,0,1, 8'hB2,1}, '{0,0, 0,0,1, 8'hB2,0},
      '{0,0, 0,0,1, 8'hB2,0}, '{1,1, 1,0,0, 8'hB2,0}, '{1,0, 1,0,0, 8'hA1,1},
      '{0,1, 0,1,1, 8'hA1,1}, '{1,0, 1,0,0, 8'hB2,1}, '{0,0, 0,0,0, 8'hA1,1},
      '{0,1, 0,1,1, 8'hA1,0}, '{0,1, 0,1,1, 8'hB2,1}};
    #2;
    check("rst_state", {4'h0, gnt_a, gnt_b, s, z, z_valid}, 16'h0);
    #10 rst = 1'b0;
    for (int i = 0; i < 26; i++) step(i);
    // u0 is mid-GNT_B here; reset between edges must clear outputs without a clock
    #3 rst = 1'b1;
    #1;
    check("async_rst", {4'h0, gnt_a, gnt_b, s, z, z_valid}, 16'h0);
    req_a = 1'b1;
    req_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("tie_h4_%0d", i), {14'h0, gnt_a, gnt_b}, 16'h2);
      check($sformatf("alt_h1_%0d", i), {14'h0, gnt_a1, gnt_b1}, (i % 2 == 0) ? 16'h2 : 16'h1);
    end
    @(posedge clk);
    #1;
    check("tie_h4_hand", {13'h0, gnt_a, gnt_b, s}, 16'h3);
`ifdef MUX_ARB_LOCK_EN
    rst = 1'b1;
    lock = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lock_hold%0d", i), {14'h0, gnt_a, gnt_b}, 16'h2);
    end
    lock = 1'b0;
    @(posedge clk);
    #1;
    check("lock_release", {14'h0, gnt_a, gnt_b}, 16'h1);
`endif
    if (sb.size() != 0) check("sb_empty", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Two-requester round-robin arbiter owning the select line of a shared 2:1 mux (inputs a, b; select s).
- Grants the mux to one requester at a time and bounds each tenure to MAX_HOLD cycles when the other side is waiting.
- Registers the mux output with a valid flag so downstream logic samples clean data.
- Sits between the two data producers and the single shared consumer path.

Parameters:
- W, 1, data width of a, b, z.
- MAX_HOLD, 4, max consecutive grant cycles while the other side requests; legal range >=1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A wants the mux.
- req_b  input  1  requester B wants the mux.
- a  input  W  data from requester A.
- b  input  W  data from requester B.
- lock  input  1  grant-extend request; present only with MUX_ARB_LOCK_EN.
- gnt_a  output  1  A currently owns the mux.
- gnt_b  output  1  B currently owns the mux.
- s  output  1  mux select; 0=a, 1=b.
- z  output  W  registered mux output.
- z_valid  output  1  z holds granted data.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; gnt_a=gnt_b=0; s=0; z=0; z_valid=0; hold_cnt=0.
  - last=B, so A wins the first tie.
  - Reset asserted mid-tenure drops the grant and z_valid immediately, with no wait for clk.
- State machine: IDLE, GNT_A, GNT_B. All transitions occur on the rising clk edge.
  - Outputs are Moore: gnt_a=(state==GNT_A), gnt_b=(state==GNT_B), both registered.
  - gnt_a and gnt_b are never both 1.
- IDLE:
  - req_a & req_b -> grant the side != last.
  - Only req_a -> GNT_A.
  - Only req_b -> GNT_B.
  - Neither -> stay in IDLE.
- GNT_A (GNT_B symmetric):
  - !req_a & req_b -> GNT_B.
  - !req_a & !req_b -> IDLE.
  - req_a & req_b & hold_cnt==MAX_HOLD-1 -> GNT_B (forced handover).
  - Otherwise stay in GNT_A.
- hold_cnt:
  - Width $clog2(MAX_HOLD)+1.
  - Cleared on every state change.
  - Increments each cycle the state is held, saturating at MAX_HOLD-1.
  - MAX_HOLD=1: strict alternation whenever both sides request.
- last: updated to the granted side on entry to GNT_A/GNT_B; unchanged in IDLE.
- s:
  - 0 in GNT_A, 1 in GNT_B.
  - In IDLE, holds its previous value (no glitch on release).
- Datapath:
  - Each cycle, z <= (state==GNT_B) ? b : a when state!=IDLE, else z holds.
  - z_valid <= (state!=IDLE).
- Latency:
  - req sampled at edge k -> gnt at edge k.
  - z/z_valid reflect that grant at edge k+1.
  - Release: z_valid falls one cycle after the grant falls.
- Simultaneous events:
  - Owner drops req in the same cycle the other raises it -> direct handover, no IDLE bubble.
  - Both drop -> IDLE.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds the lock input.
  - While the owner has req=1 and lock=1, the forced handover is suppressed and hold_cnt saturates; the tenure continues past MAX_HOLD.
  - The handover occurs on the first edge where lock=0 and hold_cnt==MAX_HOLD-1.
  - lock is ignored in IDLE.
- Undefined: no lock port; forced handover is always enforced.

Test Plan:
- Reset then req_a=1, req_b=0, a=1 for 6 cycles -> gnt_a=1 from edge 1; s=0; z=1, z_valid=1 from edge 2; gnt_b stays 0 throughout.
- req_a=req_b=1 from reset, MAX_HOLD=4 -> GNT_A for 4 cycles, GNT_B for 4 cycles, repeating. s toggles every 4 cycles; gnt_a & gnt_b never both 1.
- In GNT_A, drop req_a and raise req_b on the same edge -> next edge GNT_B, s=1, no IDLE cycle; z shows b one cycle later.
- Both req dropped -> IDLE, gnt 0, s holds 1; z_valid=0 one cycle later; z retains its last value.
- Assert rst asynchronously mid-GNT_B, between clock edges -> gnt_b, z_valid, s, z go to 0 immediately. After release with both req=1, A is granted first.
- With MUX_ARB_LOCK_EN, both requesting, lock=1 during cycles 0-9 -> GNT_A held 10 cycles. Handover to B on the first edge after lock=0.
